axi_lite_cfg_slave: RTL

AXI4-Lite responder holding the accelerator's 32-bit configuration registers; the counterpart to the AXI-Lite configuration master that programs the design before streaming starts. It accepts writes and reads, honours WSTRB byte lanes, and exposes every register as a flat output bus. It also emits a one-cycle start pulse and a read-only status word so the stream pipeline can be launched and monitored over the same interface.

---
 rtl/axi_cfg_pkg.sv | 33 +++
 rtl/axi_lite_cfg_slave.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/axi_cfg_pkg.sv
// Shared constants, FSM state types and the byte-strobe merge helper for the
// AXI4-Lite configuration register slave.
package axi_cfg_pkg;

  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [1:0] RESP_SLVERR    = 2'b10;
  localparam int         CTRL_IDX       = 0;
  localparam int         CTRL_START_BIT = 0;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HOLD_AW,
    W_HOLD_W,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  function automatic logic [31:0] merge_wstrb(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = data[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_cfg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit config registers: reg 0 is CTRL
// (bit0 self-clearing start), the last reg is a read-only STATUS mirror.
module axi_lite_cfg_slave
  import axi_cfg_pkg::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            AWADDR,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [31:0]            WDATA,
  input  logic [3:0]             WSTRB,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  input  logic [31:0]            ARADDR,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [31:0]            RDATA,
  output logic [1:0]             RRESP,
  output logic                   RVALID,
  input  logic                   RREADY,
  input  logic [31:0]            status_in,
  output logic [NUM_REGS*32-1:0] cfg_regs,
  output logic                   start_pulse
);

  localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0]  STATUS_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0]  CTRL_SEL   = IDX_W'(CTRL_IDX);
  localparam logic [31:0]       SPAN       = 32'(NUM_REGS * 4);

  logic [31:0] regs [NUM_REGS];
  wr_state_t   wstate;
  rd_state_t   rstate;
  logic [31:0] aw_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;

  logic             aw_hs, w_hs, commit, c_ok, c_start;
  logic [31:0]      c_addr, c_off, c_data, c_val;
  logic [3:0]       c_strb;
  logic [IDX_W-1:0] c_idx;

  // Pick the commit operands from the held copy or the live channel, whichever
  // arrives last; the commit happens on the edge that completes the pair.
  always_comb begin
    aw_hs   = AWVALID && AWREADY;
    w_hs    = WVALID && WREADY;
    commit  = 1'b0;
    c_addr  = aw_addr;
    c_data  = w_data;
    c_strb  = w_strb;
    case (wstate)
      W_IDLE: begin
        commit = aw_hs && w_hs;
        c_addr = AWADDR;
        c_data = WDATA;
        c_strb = WSTRB;
      end
      W_HOLD_AW: begin
        commit = w_hs;
        c_data = WDATA;
        c_strb = WSTRB;
      end
      W_HOLD_W: begin
        commit = aw_hs;
        c_addr = AWADDR;
      end
      default: ;
    endcase
    c_off   = c_addr - BASE_ADDR;
    c_idx   = c_off[IDX_W+1:2];
    c_ok    = (c_off < SPAN) && (c_idx != STATUS_IDX);
    c_val   = merge_wstrb(regs[c_idx], c_data, c_strb);
    c_start = 1'b0;
    if (c_idx == CTRL_SEL) begin
      c_start                 = c_strb[0] && c_data[CTRL_START_BIT];
      c_val[CTRL_START_BIT]   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate      <= W_IDLE;
      AWREADY     <= 1'b0;
      WREADY      <= 1'b0;
      BVALID      <= 1'b0;
      BRESP       <= RESP_OKAY;
      start_pulse <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      start_pulse <= 1'b0;
      case (wstate)
        W_IDLE: begin
          AWREADY <= 1'b1;
          WREADY  <= 1'b1;
          if (aw_hs && !w_hs) begin
            aw_addr <= AWADDR;
            AWREADY <= 1'b0;
            wstate  <= W_HOLD_AW;
          end else if (w_hs && !aw_hs) begin
            w_data <= WDATA;
            w_strb <= WSTRB;
            WREADY <= 1'b0;
            wstate <= W_HOLD_W;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: ;
      endcase
      if (commit) begin
        AWREADY <= 1'b0;
        WREADY  <= 1'b0;
        BVALID  <= 1'b1;
        BRESP   <= c_ok ? RESP_OKAY : RESP_SLVERR;
        wstate  <= W_RESP;
        if (c_ok) begin
          regs[c_idx] <= c_val;
          start_pulse <= c_start;
        end
      end
    end
  end

  logic [31:0]      r_off, r_data;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_resp;

  always_comb begin
    r_off  = ARADDR - BASE_ADDR;
    r_idx  = r_off[IDX_W+1:2];
    r_data = '0;
    r_resp = RESP_SLVERR;
    if (r_off < SPAN) begin
      r_resp = RESP_OKAY;
      r_data = (r_idx == STATUS_IDX) ? status_in : regs[r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rstate  <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          ARREADY <= 1'b1;
          if (ARVALID && ARREADY) begin
            ARREADY <= 1'b0;
            RVALID  <= 1'b1;
            RDATA   <= r_data;
            RRESP   <= r_resp;
            rstate  <= R_RESP;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
            rstate  <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    if (i == NUM_REGS - 1) begin : g_status
      assign cfg_regs[32*i +: 32] = status_in;
    end else begin : g_cfg
      assign cfg_regs[32*i +: 32] = regs[i];
    end
  end

endmodule
